// File: rtl/add_if.sv
// Operand/result bundle for the registered adder/subtractor.
// Handshake: none. The slave samples data0/data1/op on every rising clock edge
// and presents the matching result one cycle later; there is no valid/ready pair.
interface add_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] data0;
  logic [XLEN-1:0] data1;
  logic            op;
  logic [XLEN-1:0] result;

  modport master (
    output data0,
    output data1,
    output op,
    input  result
  );

  modport slave (
    input  data0,
    input  data1,
    input  op,
    output result
  );
endinterface

// File: rtl/add.sv
// Registered XLEN-bit adder/subtractor with a Kogge-Stone carry tree.
// Subtract is data0 + ~data1 + 1, with op as both the invert mask and the carry-in.
module add #(
  parameter int XLEN = 32
) (
  input  logic  clock,
  input  logic  reset,
  add_if.slave  bus
);

  localparam int LVLS = $clog2(XLEN);

  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_pb;
  logic [XLEN-1:0] w_g0;
  logic [XLEN-1:0] w_p0;
  logic [XLEN-1:0] w_c;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] r_result;

  assign w_b  = bus.data1 ^ {XLEN{bus.op}};
  assign w_pb = bus.data0 ^ w_b;

  // Tree index 0 holds the carry-in; index i holds bit i-1, so the final
  // group-generate at index i is exactly the carry into sum bit i.
  assign w_g0 = {bus.data0[XLEN-2:0] & w_b[XLEN-2:0], bus.op};
  assign w_p0 = {w_pb[XLEN-2:0], 1'b0};

  for (genvar lvl = 1; lvl <= LVLS; lvl++) begin : gen_lvl
    localparam int D = 1 << (lvl - 1);
    localparam logic [XLEN-1:0] LOW_MASK = {XLEN{1'b1}} >> (XLEN - D);

    logic [XLEN-1:0] w_g_in;
    logic [XLEN-1:0] w_p_in;
    logic [XLEN-1:0] w_g;

    if (lvl == 1) begin : gen_first
      assign w_g_in = w_g0;
      assign w_p_in = w_p0;
    end else begin : gen_next
      assign w_g_in = gen_lvl[lvl-1].w_g;
      assign w_p_in = gen_lvl[lvl-1].gen_p.w_p;
    end

    assign w_g = w_g_in | (w_p_in & (w_g_in << D));

    // Group-propagate is only needed by a following level.
    if (lvl < LVLS) begin : gen_p
      logic [XLEN-1:0] w_p;
      assign w_p = w_p_in & ((w_p_in << D) | LOW_MASK);
    end
  end

  assign w_c   = gen_lvl[LVLS].w_g;
  assign w_sum = w_pb ^ w_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_result <= '0;
    end else begin
      r_result <= w_sum;
    end
  end

  assign bus.result = r_result;

endmodule

// File: tb/tb_add.sv
// Directed and seeded-random checks of the registered adder/subtractor
// at XLEN = 32, 64 and 5.
module tb_add;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  add_if #(.XLEN(32)) bus32 ();
  add_if #(.XLEN(64)) bus64 ();
  add_if #(.XLEN(5))  bus5  ();

  add #(.XLEN(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
  add #(.XLEN(64)) dut64 (.clock(clock), .reset(reset), .bus(bus64));
  add #(.XLEN(5))  dut5  (.clock(clock), .reset(reset), .bus(bus5));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle on the 32-bit instance: apply inputs, clock once, compare.
  task automatic drive32(input string tag, input logic rst, input logic [31:0] d0,
                         input logic [31:0] d1, input logic op, input logic [31:0] exp);
    reset       = rst;
    bus32.data0 = d0;
    bus32.data1 = d1;
    bus32.op    = op;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    check(tag, 64'(bus32.result), 64'(exp_q.pop_front()));
  endtask

  initial begin
    logic [31:0] a32, b32, e32;
    logic [63:0] a64, b64, e64;
    logic [4:0]  a5, b5, e5;
    logic        o32, o64, o5;

    bus32.data0 = '0; bus32.data1 = '0; bus32.op = 1'b0;
    bus64.data0 = '0; bus64.data1 = '0; bus64.op = 1'b0;
    bus5.data0  = '0; bus5.data1  = '0; bus5.op  = 1'b0;
    #2;

    drive32("reset",       1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000);
    drive32("first_valid", 1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000);
    drive32("add_wrap",    1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000);
    drive32("sub_borrow",  1'b0, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF);
    drive32("sub_5_3",     1'b0, 32'h00000005, 32'h00000003, 1'b1, 32'h00000002);
    drive32("msb_carry",   1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000);
    drive32("alt_pattern", 1'b0, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF);
    drive32("sub_self",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000);
    drive32("sub_zero_m1", 1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000001);
    for (int i = 0; i < 3; i++) begin
      drive32("b2b_add", 1'b0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789);
      drive32("b2b_sub", 1'b0, 32'h12345678, 32'h11111111, 1'b1, 32'h01234567);
    end
    drive32("pre_reset",   1'b0, 32'h00000005, 32'h00000003, 1'b0, 32'h00000008);
    drive32("mid_reset",   1'b1, 32'h00000005, 32'h00000003, 1'b0, 32'h00000000);
    drive32("post_reset",  1'b0, 32'h00000005, 32'h00000003, 1'b0, 32'h00000008);

    void'($urandom(32'd20240611));
    for (int i = 0; i < 10000; i++) begin
      a32 = $urandom;  b32 = $urandom;  o32 = 1'($urandom_range(0, 1));
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; o64 = 1'($urandom_range(0, 1));
      a5  = 5'($urandom_range(0, 31)); b5 = 5'($urandom_range(0, 31)); o5 = 1'($urandom_range(0, 1));
      e32 = o32 ? a32 - b32 : a32 + b32;
      e64 = o64 ? a64 - b64 : a64 + b64;
      e5  = o5  ? a5 - b5   : a5 + b5;
      bus32.data0 = a32; bus32.data1 = b32; bus32.op = o32;
      bus64.data0 = a64; bus64.data1 = b64; bus64.op = o64;
      bus5.data0  = a5;  bus5.data1  = b5;  bus5.op  = o5;
      @(posedge clock);
      #1;
      check("rand32", 64'(bus32.result), 64'(e32));
      check("rand64", bus64.result, e64);
      check("rand5",  64'(bus5.result), 64'(e5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
